// File: rtl/vending_machine.sv
//==============================================================================
// Module   : vending_machine
// Brief    : 20-cent soda dispenser controller; credits N/D/Q pulses and
//            returns excess credit as a count of nickels on each vend.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module vending_machine (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_nickle,
  input  logic       i_dime,
  input  logic       i_quarter,
  output logic       o_soda,
  output logic [2:0] o_change
);

  // Credit held in units of 5 cents.
  typedef enum logic [1:0] {
    S0  = 2'd0,
    S5  = 2'd1,
    S10 = 2'd2,
    S15 = 2'd3
  } state_t;

  localparam logic [3:0] C_PRICE   = 4'd4;  // 20 cents
  localparam logic [2:0] C_NICKEL  = 3'd1;
  localparam logic [2:0] C_DIME    = 3'd2;
  localparam logic [2:0] C_QUARTER = 3'd5;

  state_t     state;
  state_t     w_state_nxt;
  logic       r_soda;
  logic [2:0] r_change;
  logic       w_soda_nxt;
  logic [2:0] w_change_nxt;
  logic [2:0] w_coin;
  logic [3:0] w_total;
  logic [3:0] w_excess;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S0;
      r_soda   <= 1'b0;
      r_change <= 3'd0;
    end else begin
      state    <= w_state_nxt;
      r_soda   <= w_soda_nxt;
      r_change <= w_change_nxt;
    end
  end

  always_comb begin
    w_coin       = 3'd0;
    w_total      = 4'd0;
    w_excess     = 4'd0;
    w_state_nxt  = state;
    w_soda_nxt   = 1'b0;
    w_change_nxt = 3'd0;

    // Only the highest-value coin of a simultaneous group is credited.
    if (i_quarter) begin
      w_coin = C_QUARTER;
    end else if (i_dime) begin
      w_coin = C_DIME;
    end else if (i_nickle) begin
      w_coin = C_NICKEL;
    end

    w_total  = {2'b00, state} + {1'b0, w_coin};
    w_excess = w_total - C_PRICE;

    if (w_total >= C_PRICE) begin
      w_state_nxt  = S0;
      w_soda_nxt   = 1'b1;
      w_change_nxt = w_excess[2:0];
    end else begin
      w_state_nxt  = state_t'(w_total[1:0]);
    end
  end

  assign o_soda   = r_soda;
  assign o_change = r_change;

endmodule

`default_nettype wire

// File: tb/tb_vending_machine.sv
//==============================================================================
// Module   : tb_vending_machine
// Brief    : Directed self-checking bench for vending_machine.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_vending_machine;

  logic       clk;
  logic       rst;
  logic       i_nickle;
  logic       i_dime;
  logic       i_quarter;
  logic       o_soda;
  logic [2:0] o_change;

  int n_cmp;
  int n_err;

  vending_machine dut (
    .clk       (clk),
    .rst       (rst),
    .i_nickle  (i_nickle),
    .i_dime    (i_dime),
    .i_quarter (i_quarter),
    .o_soda    (o_soda),
    .o_change  (o_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of inputs at the falling edge, then sample 1 ns after
  // the rising edge that consumed them.
  task automatic step(input logic r, input logic n, input logic d, input logic q);
    @(negedge clk);
    rst       = r;
    i_nickle  = n;
    i_dime    = d;
    i_quarter = q;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (dut.state !== 2'd0 || o_soda !== 1'b0 || o_change !== 3'd0) begin
      n_err++;
      $display("FAIL reset: state=%0d soda=%b change=%b want 0/0/000",
               dut.state, o_soda, o_change);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_nnd;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (dut.state !== 2'd1 || o_soda !== 1'b0 || o_change !== 3'd0) begin
      n_err++;
      $display("FAIL nnd_n1: state=%0d soda=%b change=%b want 1/0/000",
               dut.state, o_soda, o_change);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (dut.state !== 2'd2 || o_soda !== 1'b0) begin
      n_err++;
      $display("FAIL nnd_n2: state=%0d soda=%b want 2/0", dut.state, o_soda);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (dut.state !== 2'd0 || o_soda !== 1'b1 || o_change !== 3'd0) begin
      n_err++;
      $display("FAIL nnd_vend: state=%0d soda=%b change=%b want 0/1/000",
               dut.state, o_soda, o_change);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (o_soda !== 1'b0 || o_change !== 3'd0) begin
      n_err++;
      $display("FAIL nnd_idle: soda=%b change=%b want 0/000", o_soda, o_change);
    end
  endtask

  // Runs a coin sequence from S0; the last coin must vend with the given change.
  task automatic test_sequence(input string name, input logic [2:0] coins [4],
                               input int len, input logic [2:0] exp_change);
    for (int i = 0; i < len; i++) begin
      step(1'b0, coins[i][0], coins[i][1], coins[i][2]);
      if (i < len - 1) begin
        n_cmp++;
        if (o_soda !== 1'b0) begin
          n_err++;
          $display("FAIL %s_pre%0d: soda=%b want 0", name, i, o_soda);
        end
      end
    end
    n_cmp++;
    if (o_soda !== 1'b1 || o_change !== exp_change || dut.state !== 2'd0) begin
      n_err++;
      $display("FAIL %s: soda=%b change=%b state=%0d want 1/%b/0",
               name, o_soda, o_change, dut.state, exp_change);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_combinations;
    // bit0 = nickel, bit1 = dime, bit2 = quarter
    logic [2:0] s [4];
    s = '{3'b010, 3'b010, 3'b000, 3'b000}; test_sequence("dd",   s, 2, 3'd0);
    s = '{3'b100, 3'b000, 3'b000, 3'b000}; test_sequence("q",    s, 1, 3'd1);
    s = '{3'b001, 3'b100, 3'b000, 3'b000}; test_sequence("nq",   s, 2, 3'd2);
    s = '{3'b010, 3'b100, 3'b000, 3'b000}; test_sequence("dq",   s, 2, 3'd3);
    s = '{3'b001, 3'b010, 3'b100, 3'b000}; test_sequence("ndq",  s, 3, 3'd4);
    s = '{3'b010, 3'b001, 3'b010, 3'b000}; test_sequence("dnd",  s, 3, 3'd1);
    s = '{3'b001, 3'b001, 3'b001, 3'b010}; test_sequence("nnnd", s, 4, 3'd1);
    s = '{3'b110, 3'b000, 3'b000, 3'b000}; test_sequence("dq_same", s, 1, 3'd1);
    s = '{3'b111, 3'b000, 3'b000, 3'b000}; test_sequence("ndq_same", s, 1, 3'd1);
    s = '{3'b011, 3'b011, 3'b000, 3'b000}; test_sequence("nd_same", s, 2, 3'd0);
  endtask

  task automatic test_hold;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (dut.state !== 2'd2 || o_soda !== 1'b0) begin
      n_err++;
      $display("FAIL hold_1: state=%0d soda=%b want 2/0", dut.state, o_soda);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (o_soda !== 1'b1 || o_change !== 3'd0 || dut.state !== 2'd0) begin
      n_err++;
      $display("FAIL hold_2: soda=%b change=%b state=%0d want 1/000/0",
               o_soda, o_change, dut.state);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (o_soda !== 1'b0 || o_change !== 3'd0) begin
      n_err++;
      $display("FAIL hold_idle: soda=%b change=%b want 0/000", o_soda, o_change);
    end
  endtask

  task automatic test_reset_mid;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (dut.state !== 2'd3) begin
      n_err++;
      $display("FAIL rmid_s15: state=%0d want 3", dut.state);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (dut.state !== 2'd0 || o_soda !== 1'b0 || o_change !== 3'd0) begin
      n_err++;
      $display("FAIL rmid: state=%0d soda=%b change=%b want 0/0/000",
               dut.state, o_soda, o_change);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (dut.state !== 2'd0 || o_soda !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_after: state=%0d soda=%b want 0/0", dut.state, o_soda);
    end
  endtask

  task automatic test_back_to_back;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (o_soda !== 1'b1 || o_change !== 3'd1 || dut.state !== 2'd0) begin
      n_err++;
      $display("FAIL b2b_qq: soda=%b change=%b state=%0d want 1/001/0",
               o_soda, o_change, dut.state);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (o_soda !== 1'b0 || o_change !== 3'd0 || dut.state !== 2'd2) begin
      n_err++;
      $display("FAIL b2b_d: soda=%b change=%b state=%0d want 0/000/2",
               o_soda, o_change, dut.state);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (dut.state !== 2'd2 || o_soda !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_hold: state=%0d soda=%b want 2/0", dut.state, o_soda);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (o_soda !== 1'b1 || o_change !== 3'd4) begin
      n_err++;
      $display("FAIL b2b_max: soda=%b change=%b want 1/100", o_soda, o_change);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    i_nickle  = 1'b0;
    i_dime    = 1'b0;
    i_quarter = 1'b0;
    test_reset();
    test_nnd();
    test_combinations();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
